// File: rtl/mips_debug_unit_pkg.sv
// Shared constants for the MIPS host debug unit: command codes, frame header, FSM encodings.
// DEBUG_UNIT_CHECKSUM_EN adds a trailing XOR byte to every dump frame.
package mips_debug_unit_pkg;

   localparam logic [7:0] CMD_STEP     = 8'h53;
   localparam logic [7:0] CMD_CONT     = 8'h43;
   localparam logic [7:0] CMD_DUMP     = 8'h44;
   localparam logic [7:0] CMD_HALT     = 8'h48;
   localparam logic [7:0] FRAME_HEADER = 8'hA5;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_STEP   = 4'd1;
   localparam logic [3:0] ST_CONT   = 4'd2;
   localparam logic [3:0] ST_SETTLE = 4'd3;
   localparam logic [3:0] ST_SEL    = 4'd4;
   localparam logic [3:0] ST_LATCH  = 4'd5;
   localparam logic [3:0] ST_SEND   = 4'd6;
   localparam logic [3:0] ST_CSUM   = 4'd7;
   localparam logic [3:0] ST_DONE   = 4'd8;

   // Which part of the frame the word currently in the serializer belongs to.
   typedef enum logic [2:0] {
      PH_HDR,
      PH_PC,
      PH_ALU,
      PH_REG,
      PH_MEM,
      PH_CSUM
   } phase_e;

`ifdef DEBUG_UNIT_CHECKSUM_EN
   localparam int FRAME_BYTES = 202;
`else
   localparam int FRAME_BYTES = 201;
`endif

endpackage

// File: rtl/mips_debug_unit_word_serializer.sv
// Byte serializer: loads up to NB bits and emits them LSB-first over a valid/ready byte port.
module debug_word_serializer #(
   parameter int NB      = 32,
   parameter int NB_BYTE = 8,
   parameter int CNT_W   = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_load,
   input  logic [NB-1:0]      i_data,
   input  logic [CNT_W-1:0]   i_nbytes,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_done
);

   logic [NB-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             xfer;

   assign o_tx_valid = (cnt_q != '0);
   assign o_tx_data  = o_tx_valid ? shift_q[NB_BYTE-1:0] : '0;
   assign xfer       = o_tx_valid & i_tx_ready;
   assign o_done     = xfer & (cnt_q == CNT_W'(1));

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (i_load) begin
         shift_d = i_data;
         cnt_d   = i_nbytes;
      end else if (xfer) begin
         shift_d = shift_q >> NB_BYTE;
         cnt_d   = cnt_q - 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/mips_debug_unit.sv
// Host-side debug controller for the MIPS pipeline: command decode, step control, state dump.
// Define DEBUG_UNIT_CHECKSUM_EN to append an XOR checksum byte after the memory words.
module mips_debug_unit
   import mips_debug_unit_pkg::*;
#(
   parameter int NB              = 32,
   parameter int NB_BYTE         = 8,
   parameter int NB_REG_SEL      = 5,
   parameter int N_REGS          = 32,
   parameter int TAM_DATA_MEMORY = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NB_BYTE-1:0]    i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [NB_BYTE-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   input  logic [NB-1:0]         i_mips_pc,
   input  logic [NB-1:0]         i_mips_alu_result,
   input  logic [NB-1:0]         i_mips_register_data,
   input  logic [NB-1:0]         i_mips_data_memory,
   output logic                  o_step,
   output logic [NB_REG_SEL-1:0] o_debug_mips_register_number,
   output logic [NB-1:0]         o_debug_address,
   output logic                  o_busy
);

   localparam int IDX_W      = NB_REG_SEL;
   localparam int WORD_BYTES = NB / NB_BYTE;
   localparam int CNT_W      = $clog2(WORD_BYTES + 1);

   localparam logic [CNT_W-1:0] NBYTES_WORD = CNT_W'(WORD_BYTES);
   localparam logic [CNT_W-1:0] NBYTES_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] REG_LAST    = IDX_W'(N_REGS - 1);
   localparam logic [IDX_W-1:0] MEM_LAST    = IDX_W'(TAM_DATA_MEMORY - 1);

   logic [3:0]            state_q, state_d;
   phase_e                phase_q, phase_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NB_REG_SEL-1:0] reg_sel_q, reg_sel_d;
   logic [NB-1:0]         addr_q, addr_d;
   logic [NB-1:0]         alu_q, alu_d;

   logic                  ser_load;
   logic [NB-1:0]         ser_data;
   logic [CNT_W-1:0]      ser_nbytes;
   logic                  ser_done;
   logic                  rx_accept;

`ifdef DEBUG_UNIT_CHECKSUM_EN
   logic [NB_BYTE-1:0]    csum_q, csum_d;
`endif

   assign o_rx_ready = (state_q == ST_IDLE) || (state_q == ST_CONT);
   assign o_step     = (state_q == ST_STEP) || (state_q == ST_CONT);
   assign o_busy     = (state_q != ST_IDLE);
   assign rx_accept  = i_rx_valid & o_rx_ready;

   assign o_debug_mips_register_number = reg_sel_q;
   assign o_debug_address              = addr_q;

   debug_word_serializer #(
      .NB      (NB),
      .NB_BYTE (NB_BYTE),
      .CNT_W   (CNT_W)
   ) u_serializer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (ser_load),
      .i_data     (ser_data),
      .i_nbytes   (ser_nbytes),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_done     (ser_done)
   );

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      idx_d      = idx_q;
      reg_sel_d  = reg_sel_q;
      addr_d     = addr_q;
      alu_d      = alu_q;
      ser_load   = 1'b0;
      ser_data   = '0;
      ser_nbytes = NBYTES_WORD;
`ifdef DEBUG_UNIT_CHECKSUM_EN
      csum_d = csum_q;
      if (o_tx_valid && i_tx_ready && phase_q != PH_HDR && phase_q != PH_CSUM)
         csum_d = csum_q ^ o_tx_data;
`endif

      case (state_q)
         ST_IDLE: begin
            if (rx_accept) begin
               case (i_rx_data)
                  CMD_STEP: state_d = ST_STEP;
                  CMD_CONT: state_d = ST_CONT;
                  CMD_DUMP: state_d = ST_SETTLE;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_STEP: state_d = ST_SETTLE;
         ST_CONT: begin
            if (rx_accept && i_rx_data == CMD_HALT)
               state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            ser_load   = 1'b1;
            ser_data   = NB'(FRAME_HEADER);
            ser_nbytes = NBYTES_ONE;
            phase_d    = PH_HDR;
            state_d    = ST_SEND;
`ifdef DEBUG_UNIT_CHECKSUM_EN
            csum_d = '0;
`endif
         end
         ST_SEL: begin
            if (phase_q == PH_REG)
               reg_sel_d = NB_REG_SEL'(idx_q);
            else
               addr_d = NB'({idx_q, 2'b00});
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            ser_load = 1'b1;
            case (phase_q)
               PH_PC: begin
                  ser_data = i_mips_pc;
                  alu_d    = i_mips_alu_result;
               end
               PH_REG:  ser_data = i_mips_register_data;
               PH_MEM:  ser_data = i_mips_data_memory;
               default: ser_data = '0;
            endcase
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (ser_done) begin
               case (phase_q)
                  PH_HDR: begin
                     phase_d = PH_PC;
                     state_d = ST_LATCH;
                  end
                  // ALU word was captured alongside PC; chain it straight in.
                  PH_PC: begin
                     ser_load = 1'b1;
                     ser_data = alu_q;
                     phase_d  = PH_ALU;
                  end
                  PH_ALU: begin
                     phase_d = PH_REG;
                     idx_d   = '0;
                     state_d = ST_SEL;
                  end
                  PH_REG: begin
                     if (idx_q == REG_LAST) begin
                        phase_d = PH_MEM;
                        idx_d   = '0;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                     state_d = ST_SEL;
                  end
                  PH_MEM: begin
                     if (idx_q == MEM_LAST) begin
`ifdef DEBUG_UNIT_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                     end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEL;
                     end
                  end
                  default: state_d = ST_DONE;
               endcase
            end
         end
`ifdef DEBUG_UNIT_CHECKSUM_EN
         ST_CSUM: begin
            ser_load   = 1'b1;
            ser_data   = NB'(csum_q);
            ser_nbytes = NBYTES_ONE;
            phase_d    = PH_CSUM;
            state_d    = ST_SEND;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_HDR;
         idx_q     <= '0;
         reg_sel_q <= '0;
         addr_q    <= '0;
         alu_q     <= '0;
`ifdef DEBUG_UNIT_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         reg_sel_q <= reg_sel_d;
         addr_q    <= addr_d;
         alu_q     <= alu_d;
`ifdef DEBUG_UNIT_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_mips_debug_unit.sv
// Self-checking bench for mips_debug_unit: toy pipeline stub, frame model and byte scoreboard.
module tb_mips_debug_unit;

`ifdef DEBUG_UNIT_CHECKSUM_EN
   localparam int FRAME_LEN = 202;
`else
   localparam int FRAME_LEN = 201;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [31:0] mips_pc;
   logic [31:0] mips_alu;
   logic [31:0] mips_reg;
   logic [31:0] mips_mem;
   logic        step;
   logic [4:0]  reg_sel;
   logic [31:0] dbg_addr;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int ready_mode = 0;
   int step_cnt = 0;
   int step_rises = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got[$];

   always #5 clk = ~clk;

   mips_debug_unit dut (
      .i_clk                        (clk),
      .i_reset                      (rst),
      .i_rx_data                    (rx_data),
      .i_rx_valid                   (rx_valid),
      .o_rx_ready                   (rx_ready),
      .o_tx_data                    (tx_data),
      .o_tx_valid                   (tx_valid),
      .i_tx_ready                   (tx_ready),
      .i_mips_pc                    (mips_pc),
      .i_mips_alu_result            (mips_alu),
      .i_mips_register_data         (mips_reg),
      .i_mips_data_memory           (mips_mem),
      .o_step                       (step),
      .o_debug_mips_register_number (reg_sel),
      .o_debug_address              (dbg_addr),
      .o_busy                       (busy)
   );

   // Toy pipeline: PC advances 4 per step; ADDI $7,$1,3 writes back on the 4th step.
   logic [31:0] stub_pc = '0;
   int          stub_steps = 0;
   logic        wb_done = 1'b0;

   function automatic logic [31:0] reg_init(input logic [31:0] i);
      return i * 32'h0101_0111;
   endfunction

   function automatic logic [31:0] mem_init(input logic [31:0] i);
      return 32'hDEAD_0000 | (i << 4) | i;
   endfunction

   function automatic logic [31:0] reg_exp(input logic [31:0] i, input int steps);
      return (i == 32'd7 && steps >= 4) ? reg_init(32'd1) + 32'd3 : reg_init(i);
   endfunction

   always @(posedge clk) begin
      if (step) begin
         stub_pc    <= stub_pc + 32'd4;
         stub_steps <= stub_steps + 1;
         if (stub_steps == 3) wb_done <= 1'b1;
      end
   end

   logic [31:0] mem_idx;
   assign mem_idx  = dbg_addr >> 2;
   assign mips_pc  = stub_pc;
   assign mips_alu = stub_pc + 32'h1000;
   assign mips_reg = (reg_sel == 5'd7 && wb_done) ? reg_init(32'd1) + 32'd3 : reg_init(32'(reg_sel));
   assign mips_mem = (mem_idx < 32'd16) ? mem_init(mem_idx) : 32'd0;

   task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_tests++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
      end
   endtask

   // Frame as the host should see it, given how many steps the pipeline has taken.
   task automatic start_frame(input int steps);
      logic [31:0] w;
      logic [7:0]  cs;
      cs = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 2 + 32 + 16; k++) begin
         if (k == 0)       w = 32'(4 * steps);
         else if (k == 1)  w = 32'(4 * steps) + 32'h1000;
         else if (k < 34)  w = reg_exp(32'(k - 2), steps);
         else              w = mem_init(32'(k - 34));
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            cs = cs ^ w[8*b +: 8];
         end
      end
`ifdef DEBUG_UNIT_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   initial begin : tx_ready_driver
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         tx_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      end
   end

   initial begin : byte_scoreboard
      logic       stall;
      logic [7:0] stall_data;
      stall = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("stall_valid_held", 32'(tx_valid), 32'd1);
               check("stall_data_held", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
               check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0)
                  check($sformatf("frame_byte_%0d", got.size()), 32'(tx_data), 32'(exp_q.pop_front()));
               got.push_back(tx_data);
            end
            stall = tx_valid && !tx_ready;
            stall_data = tx_data;
         end
      end
   end

   initial begin : step_monitor
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (step) step_cnt++;
         if (step && !prev) step_rises++;
         prev = step;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check({name, "_finished"}, 32'(busy), 32'd0);
      check({name, "_all_bytes_seen"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin : main
      int base;
      int steps0;
      int rises0;
      int model_steps;
      logic [7:0] frame1[$];
      logic [7:0] x;

      model_steps = 0;
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_step", 32'(step), 32'd0);
      check("reset_tx_valid", 32'(tx_valid), 32'd0);
      check("reset_tx_data", 32'(tx_data), 32'd0);
      check("reset_reg_sel", 32'(reg_sel), 32'd0);
      check("reset_addr", dbg_addr, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rx_ready", 32'(rx_ready), 32'd1);
      rst = 1'b0;

      // Plain dump after reset.
      base = got.size();
      send_cmd(8'h44);
      start_frame(model_steps);
      wait_idle("dump1");
      check("dump1_len", 32'(got.size() - base), 32'(FRAME_LEN));
      check("dump1_header", 32'(got[base]), 32'hA5);
      for (int i = 1; i <= 4; i++) check("dump1_pc_byte", 32'(got[base + i]), 32'h00);
      for (int i = 0; i < FRAME_LEN; i++) frame1.push_back(got[base + i]);

      // Unknown command in IDLE is dropped.
      send_cmd(8'h58);
      @(negedge clk);
      check("idle_x_ignored", 32'(busy), 32'd0);

      // Throttled dump: same stream, commands sent mid-frame are dropped.
      ready_mode = 1;
      base = got.size();
      steps0 = step_cnt;
      send_cmd(8'h44);
      start_frame(model_steps);
      repeat (40) @(negedge clk);
      check("busy_mid_frame", 32'(rx_ready), 32'd0);
      send_cmd(8'h53);
      wait_idle("dump_slow");
      ready_mode = 0;
      check("dump_slow_len", 32'(got.size() - base), 32'(FRAME_LEN));
      for (int i = 0; i < FRAME_LEN; i++)
         if (got.size() > base + i) check($sformatf("replay_byte_%0d", i), 32'(got[base + i]), 32'(frame1[i]));
      check("dropped_step", 32'(step_cnt - steps0), 32'd0);
      repeat (3) @(negedge clk);
      check("dropped_cmd_idle", 32'(busy), 32'd0);

      // Single step.
      base = got.size();
      steps0 = step_cnt;
      rises0 = step_rises;
      send_cmd(8'h53);
      model_steps = model_steps + 1;
      start_frame(model_steps);
      wait_idle("step1");
      check("step1_cycles", 32'(step_cnt - steps0), 32'd1);
      check("step1_pulses", 32'(step_rises - rises0), 32'd1);
      check("step1_pc_lsb", 32'(got[base + 1]), 32'h04);

      // Three more steps, then a dump shows the write-back.
      for (int s = 0; s < 3; s++) begin
         send_cmd(8'h53);
         model_steps = model_steps + 1;
         start_frame(model_steps);
         wait_idle("step_n");
      end
      base = got.size();
      send_cmd(8'h44);
      start_frame(model_steps);
      wait_idle("dump_wb");
      for (int i = 0; i < 4; i++) check("r0_byte", 32'(got[base + 9 + i]), 32'h00);
      check("r7_b0", 32'(got[base + 37]), 32'h14);
      check("r7_b1", 32'(got[base + 38]), 32'h01);
      check("r7_b2", 32'(got[base + 39]), 32'h01);
      check("r7_b3", 32'(got[base + 40]), 32'h01);

      // Continuous run: C, 10 idle cycles, ignored X, then H -> 14 step cycles.
      base = got.size();
      steps0 = step_cnt;
      rises0 = step_rises;
      send_cmd(8'h43);
      repeat (10) @(negedge clk);
      check("cont_busy", 32'(busy), 32'd1);
      send_cmd(8'h58);
      send_cmd(8'h48);
      model_steps = model_steps + 14;
      start_frame(model_steps);
      wait_idle("cont");
      check("cont_cycles", 32'(step_cnt - steps0), 32'd14);
      check("cont_pulses", 32'(step_rises - rises0), 32'd1);
      check("cont_pc_lsb", 32'(got[base + 1]), 32'h48);
`ifdef DEBUG_UNIT_CHECKSUM_EN
      x = 8'h00;
      for (int i = 1; i < 201; i++) x = x ^ got[base + i];
      check("checksum_byte", 32'(got[base + 201]), 32'(x));
`else
      x = 8'h00;
      check("frame_len_no_csum", 32'(got.size() - base), 32'd201);
`endif

      // Reset in the middle of a dump.
      base = got.size();
      send_cmd(8'h44);
      start_frame(model_steps);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (got.size() - base >= 50) break;
      end
      check("reached_byte_50", 32'(got.size() - base >= 50), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_tx_valid", 32'(tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rx_ready", 32'(rx_ready), 32'd1);
      exp_q.delete();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      base = got.size();
      send_cmd(8'h44);
      start_frame(model_steps);
      wait_idle("after_abort");
      check("after_abort_len", 32'(got.size() - base), 32'(FRAME_LEN));
      check("after_abort_header", 32'(got[base]), 32'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
